// File: rtl/t_ff.sv
// ----------------------------------------------------------------------------
// t_ff: one stage of the ripple counter.
//
// A negative-edge D flip-flop with its D input tied to its own inverted Q. The
// stage therefore toggles on every falling edge of its clk input. A low level
// on reset clears the stage immediately, without waiting for a clock edge.
//
// Ports:
//   q      output  stage state
//   clk    input   toggle clock; the stage toggles on its falling edge
//   reset  input   asynchronous active-low clear
// ----------------------------------------------------------------------------
module t_ff (
    output logic q,
    input  logic clk,
    input  logic reset
);

    logic q_q;
    logic q_d;

    // Toggle: the next state is always the inverse of the current state.
    always_comb begin
        q_d = ~q_q;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ripple_carry_counter.sv
// ----------------------------------------------------------------------------
// ripple_carry_counter: free-running asynchronous (ripple) binary up-counter.
//
// WIDTH toggle stages are chained. Stage 0 is clocked by the falling edge of
// clk, and stage i is clocked by the falling edge of q[i-1]. A 1->0 transition
// on a lower bit is exactly a carry into the next bit, so the chain counts up
// by one for each falling clk edge, modulo 2^WIDTH, with no carry-out.
//
// Higher bits settle in cascade after each falling clk edge. Sample q in the
// clk domain only after settling, for example on the rising edge.
//
// The stages deliberately share no common clock. Release of reset must be kept
// away from a falling clk edge. An edge that coincides with the release is not
// counted.
//
// Parameters:
//   WIDTH  number of counter bits, 1..32
//
// Ports:
//   q      output  [WIDTH-1:0] current count; q[0] is the LSB
//   clk    input   counter clock; counted on its falling edge
//   reset  input   asynchronous active-low clear of every stage
// ----------------------------------------------------------------------------
module ripple_carry_counter #(
    parameter int unsigned WIDTH = 4
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset
);

    // Clock seen by each stage: clk for the LSB, the previous bit otherwise.
    logic [WIDTH-1:0] stage_clk;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            assign stage_clk[i] = clk;
        end else begin : g_upper
            assign stage_clk[i] = q[i-1];
        end

        t_ff u_t_ff (
            .q     (q[i]),
            .clk   (stage_clk[i]),
            .reset (reset)
        );
    end

endmodule

// File: tb/tb_ripple_carry_counter.sv
// ----------------------------------------------------------------------------
// tb_ripple_carry_counter: self-checking bench for ripple_carry_counter.
//
// The bench runs three instances (WIDTH = 4, 1, 8) from a shared clk and reset.
// A reference model counts falling clk edges and pushes the expected counts
// for all three widths onto a scoreboard queue. A checker pops one entry on
// each rising clk edge, after the ripple has settled, and compares it with the
// DUT outputs. The main sequence adds directed checks: reset hold, the count
// of 5, the 15/0/1 wrap, the asynchronous clear mid-count, and the first count
// after release.
// ----------------------------------------------------------------------------
module tb_ripple_carry_counter;

    typedef struct packed {
        logic [3:0] q4;
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [7:0] q8;

    int unsigned errors;
    int unsigned checks;

    exp_t        sb_q[$];
    int unsigned model_cnt;

    ripple_carry_counter #(.WIDTH(4)) u_dut4 (
        .q     (q4),
        .clk   (clk),
        .reset (reset)
    );

    ripple_carry_counter #(.WIDTH(1)) u_dut1 (
        .q     (q1),
        .clk   (clk),
        .reset (reset)
    );

    ripple_carry_counter #(.WIDTH(8)) u_dut8 (
        .q     (q8),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts every falling clk edge seen while reset is high.
    // It samples 1 unit after the edge. Reset never changes within 1 unit of a
    // falling edge.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            model_cnt = 0;
        end else begin
            model_cnt = model_cnt + 1;
        end
        e.q4 = model_cnt[3:0];
        e.q1 = model_cnt[0];
        e.q8 = model_cnt[7:0];
        sb_q.push_back(e);
    end

    // Compare on the rising edge, half a period after the update.
    always @(posedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("sb_q4", {28'd0, q4}, {28'd0, e.q4});
            check_eq("sb_q1", {31'd0, q1}, {31'd0, e.q1});
            check_eq("sb_q8", {24'd0, q8}, {24'd0, e.q8});
        end
    end

    initial begin
        errors    = 0;
        checks    = 0;
        model_cnt = 0;
        reset     = 1'b0;

        // Reset hold: clk toggles, q must be a defined 0.
        #3;
        check_eq("hold_a", {28'd0, q4}, 32'd0);
        #5;
        check_eq("hold_b", {28'd0, q4}, 32'd0);
        check_eq("hold_q8", {24'd0, q8}, 32'd0);

        // Release at t=12, clear of the falling edge at t=10.
        #4;
        reset = 1'b1;

        repeat (5) @(negedge clk);
        #1;
        check_eq("cnt5", {28'd0, q4}, 32'd5);

        repeat (10) @(negedge clk);
        #1;
        check_eq("cnt15", {28'd0, q4}, 32'd15);

        @(negedge clk);
        #1;
        check_eq("wrap16", {28'd0, q4}, 32'd0);
        check_eq("q8_16", {24'd0, q8}, 32'd16);

        @(negedge clk);
        #1;
        check_eq("wrap17", {28'd0, q4}, 32'd1);

        repeat (8) @(negedge clk);
        #1;
        check_eq("pre_rst", {28'd0, q4}, 32'd9);

        // Assert reset away from any clk edge. Every stage clears immediately.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_q4", {28'd0, q4}, 32'd0);
        check_eq("async_q1", {31'd0, q1}, 32'd0);
        check_eq("async_q8", {24'd0, q8}, 32'd0);

        @(negedge clk);
        #1;
        check_eq("rst_ignore", {28'd0, q4}, 32'd0);
        #1;
        reset = 1'b1;

        @(negedge clk);
        #1;
        check_eq("post_rel4", {28'd0, q4}, 32'd1);
        check_eq("post_rel1", {31'd0, q1}, 32'd1);
        check_eq("post_rel8", {24'd0, q8}, 32'd1);

        // Free run long enough for the 8-bit instance to wrap 255 -> 0.
        repeat (300) @(negedge clk);
        #1;
        check_eq("end_q4", {28'd0, q4}, 32'd13);
        check_eq("end_q1", {31'd0, q1}, 32'd1);
        check_eq("end_q8", {24'd0, q8}, 32'd45);

        // Let the checker drain the last scoreboard entry.
        @(posedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
